tx_piso_comma: RTL

- Transmit-side 10-bit parallel-in/serial-out stage.
- Directly upstream, across the serial channel, of the receive deserializer.
- Serialises 10-bit encoded words LSB-first, one bit per BitCLK, using a valid/ready handshake.
- Fills empty slots with alternating K28.5 comma words; periodically forces a comma so the receiver's comma aligner stays locked.

---
 rtl/tx_piso_comma.sv | 113 +++++++++++
 1 files changed

// File: rtl/tx_piso_comma.sv
// Purpose: 10-bit parallel-in/serial-out transmitter, LSB first, with K28.5 comma idle fill and periodic forced commas.
// Latency: a word accepted at edge k drives its bit 0 on Serial right after edge k; each word occupies 10 BitCLKs, back to back.
// Backpressure: TxReady pulses one cycle in ten (load slot), withheld on forced-comma slots; the source holds TxValid/data until taken.
// Optional: define TX_PRBS7_EN to add the PrbsEn input and a PRBS7 (x^7+x^6+1) test-pattern mode switched on word boundaries.
module tx_piso_comma #(
  parameter logic [9:0] COMMA_P       = 10'd380,
  parameter logic [9:0] COMMA_N       = 10'd643,
  parameter int         SYNC_INTERVAL = 16
) (
  input  logic       BitCLK,
  input  logic       Reset,
  input  logic [9:0] TxParallel_10,
  input  logic       TxValid,
`ifdef TX_PRBS7_EN
  input  logic       PrbsEn,
`endif
  output logic       TxReady,
  output logic       Serial,
  output logic       Idle
);

  logic [3:0] bit_cnt;
  logic [9:0] shift_reg;
  logic [7:0] data_cnt;
  logic       comma_tgl;
  logic       serial_q;
  logic       idle_q;
  logic       load_slot;
  logic       forced_comma;
  logic       prbs_active;
  logic [9:0] comma_word;

  // A zero interval turns forcing off entirely.
  localparam bit FORCE_EN = (SYNC_INTERVAL != 0);

`ifdef TX_PRBS7_EN
  logic       prbs_mode;
  logic [6:0] lfsr;
  logic [6:0] lfsr_nxt;

  // PRBS7 step for x^7+x^6+1; the output bit is the MSB.
  always_comb begin
    lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end
  assign prbs_active = prbs_mode;
`else
  assign prbs_active = 1'b0;
`endif

  assign load_slot    = (bit_cnt == 4'd9);
  assign forced_comma = FORCE_EN && (int'(data_cnt) == SYNC_INTERVAL);
  assign comma_word   = comma_tgl ? COMMA_N : COMMA_P;

  // The slot is only offered when no comma is being forced and no test pattern is running.
  assign TxReady = load_slot && !forced_comma && !prbs_active;
  assign Serial  = serial_q;
  assign Idle    = idle_q;

  // Bit counter, shifter, comma alternation and data-run counter; Serial is registered so inputs never reach it combinationally.
  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      bit_cnt   <= 4'd9;
      shift_reg <= '0;
      data_cnt  <= '0;
      comma_tgl <= 1'b0;
      serial_q  <= 1'b0;
      idle_q    <= 1'b0;
`ifdef TX_PRBS7_EN
      prbs_mode <= 1'b0;
      lfsr      <= 7'h7F;
`endif
    end else begin
      bit_cnt <= load_slot ? 4'd0 : bit_cnt + 4'd1;
      if (load_slot) begin
`ifdef TX_PRBS7_EN
        prbs_mode <= PrbsEn;
        if (PrbsEn) begin
          // Pattern word: counters keep running, comma state untouched.
          shift_reg <= '0;
          serial_q  <= lfsr[6];
          lfsr      <= lfsr_nxt;
          idle_q    <= 1'b0;
        end else
`endif
        if (TxValid && TxReady) begin
          shift_reg <= TxParallel_10;
          serial_q  <= TxParallel_10[0];
          idle_q    <= 1'b0;
          if (data_cnt != 8'hFF) begin
            data_cnt <= data_cnt + 8'd1;
          end
        end else begin
          // Inserted or forced comma: alternate running disparity and restart the data run.
          shift_reg <= comma_word;
          serial_q  <= comma_word[0];
          comma_tgl <= ~comma_tgl;
          data_cnt  <= '0;
          idle_q    <= 1'b1;
        end
      end else begin
        shift_reg <= shift_reg >> 1;
`ifdef TX_PRBS7_EN
        if (prbs_mode) begin
          serial_q <= lfsr[6];
          lfsr     <= lfsr_nxt;
        end else
`endif
        serial_q <= shift_reg[1];
      end
    end
  end

endmodule
